// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared state encodings, counter width and address check for the data-memory responder
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int LAT_W = 4;

    // Misaligned word access or any address bit above the array range is an error.
    function automatic logic addr_err(input logic [31:0] addr, input int depth);
        int aw;
        aw = $clog2(depth);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word RAM, read-first, no reset
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - valid/ready data-memory slave with wait states and error reporting
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int              AW        = $clog2(DEPTH);
    localparam bit              IMMEDIATE = (LATENCY == 0);
    localparam logic [LAT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

    state_t            state_q;
    logic [LAT_W-1:0]  cnt_q;
    logic              write_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              load_ok_q;

    logic              in_idle;
    logic              enter_resp;
    logic              acc_write;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_err;
    logic              ram_we;
    logic [31:0]       ram_rdata;

    assign in_idle = (state_q == ST_IDLE);

    // With zero latency the access happens on the accepting edge, so the RAM sees the live request.
    assign acc_write = in_idle ? req_write : write_q;
    assign acc_addr  = in_idle ? req_addr  : addr_q;
    assign acc_wdata = in_idle ? req_wdata : wdata_q;
    assign acc_err   = addr_err(acc_addr, DEPTH);

    assign enter_resp = (in_idle && req_valid && IMMEDIATE)
                     || (state_q == ST_WAIT && cnt_q == '0);
    assign ram_we     = enter_resp && acc_write && !acc_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (IMMEDIATE) begin
                            state_q   <= ST_RESP;
                            err_q     <= acc_err;
                            load_ok_q <= !req_write && !acc_err;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q   <= ST_RESP;
                        err_q     <= acc_err;
                        load_ok_q <= !write_q && !acc_err;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q   <= ST_IDLE;
                        err_q     <= 1'b0;
                        load_ok_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // RAM output register is only exposed for successful loads; it is stable while in RESP.
    assign req_ready  = in_idle;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = load_ok_q ? ram_rdata : 32'd0;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LATENCY 2 and LATENCY 0
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        rdy2, vld2, err2;
    logic [31:0] rdata2;
    logic        rdy0, vld0, err0;
    logic [31:0] rdata0;

    logic        rdy_m, vld_m, err_m;
    logic [31:0] rdata_m;

    int          errors;
    int          checks;
    logic [32:0] sb_q [$];
    logic [31:0] model_mem [256];
    bit          model_wr  [256];

    assign rdy_m   = sel ? rdy0   : rdy2;
    assign vld_m   = sel ? vld0   : vld2;
    assign err_m   = sel ? err0   : err2;
    assign rdata_m = sel ? rdata0 : rdata2;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid & ~sel),
        .req_ready  (rdy2),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (vld2),
        .resp_ready (resp_ready),
        .resp_rdata (rdata2),
        .resp_err   (err2)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid & sel),
        .req_ready  (rdy0),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (vld0),
        .resp_ready (resp_ready),
        .resp_rdata (rdata0),
        .resp_err   (err0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic eerr, input logic [31:0] edata);
        int          n;
        int          low;
        int          exp_lat;
        logic [32:0] e;
        exp_lat   = sel ? 0 : 2;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        while (rdy_m !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (rdy_m !== 1'b1) begin
            errors++; checks++;
            $display("FAIL accept_timeout addr=%h req_ready=%b required 1", a, rdy_m);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        sb_q.push_back({eerr, edata});
        n = 0; low = 0;
        while (vld_m !== 1'b1 && n < 100) begin
            if (rdy_m === 1'b0) low++;
            @(posedge clk); #1; n++;
        end
        e = sb_q.pop_front();
        if (vld_m !== 1'b1) begin
            errors++; checks++;
            $display("FAIL resp_timeout addr=%h resp_valid=%b required 1", a, vld_m);
            return;
        end
        if (rdy_m === 1'b0) low++;
        checks++;
        if (n !== exp_lat) begin
            errors++;
            $display("FAIL resp_latency addr=%h got=%0d required=%0d", a, n, exp_lat);
        end
        checks++;
        if (err_m !== e[32]) begin
            errors++;
            $display("FAIL resp_err addr=%h got=%b required=%b", a, err_m, e[32]);
        end
        checks++;
        if (rdata_m !== e[31:0]) begin
            errors++;
            $display("FAIL resp_rdata addr=%h got=%h required=%h", a, rdata_m, e[31:0]);
        end
        @(posedge clk); #1;
        checks++;
        if (rdy_m !== 1'b1 || vld_m !== 1'b0) begin
            errors++;
            $display("FAIL post_handshake addr=%h ready=%b valid=%b required 1/0", a, rdy_m, vld_m);
        end
        checks++;
        if (low !== exp_lat + 1) begin
            errors++;
            $display("FAIL ready_low_cycles addr=%h got=%0d required=%0d", a, low, exp_lat + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (rdy2 !== 1'b1 || vld2 !== 1'b0 || rdata2 !== 32'd0 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_l2 got ready=%b valid=%b rdata=%h err=%b required 1/0/0/0", rdy2, vld2, rdata2, err2);
        end
        checks++;
        if (rdy0 !== 1'b1 || vld0 !== 1'b0 || rdata0 !== 32'd0 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_l0 got ready=%b valid=%b rdata=%h err=%b required 1/0/0/0", rdy0, vld0, rdata0, err0);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
        txn(1'b0, 32'h10, 32'd0,        1'b0, 32'hDEADBEEF);
    endtask

    task automatic test_errors();
        txn(1'b1, 32'h13,  32'h0BADF00D, 1'b1, 32'd0);
        txn(1'b0, 32'h10,  32'd0,        1'b0, 32'hDEADBEEF);
        txn(1'b0, 32'h400, 32'd0,        1'b1, 32'd0);
    endtask

    task automatic test_backpressure();
        int n;
        resp_ready = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h10;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_write  = 1'b1;
        req_wdata  = 32'h55AA55AA;
        n = 0;
        while (vld_m !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (vld_m !== 1'b1 || rdata_m !== 32'hDEADBEEF || rdy_m !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d valid=%b rdata=%h ready=%b required 1/deadbeef/0", i, vld_m, rdata_m, rdy_m);
            end
            @(posedge clk); #1;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rdy_m !== 1'b1 || vld_m !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release ready=%b valid=%b required 1/0", rdy_m, vld_m);
        end
        txn(1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
    endtask

    task automatic test_reset_mid();
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (rdy_m !== 1'b1 || vld_m !== 1'b0 || rdata_m !== 32'd0 || err_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got ready=%b valid=%b rdata=%h err=%b required 1/0/0/0", rdy_m, vld_m, rdata_m, err_m);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (vld_m !== 1'b0) begin
            errors++;
            $display("FAIL stale_resp valid=%b required 0", vld_m);
        end
        txn(1'b1, 32'h20, 32'h1, 1'b0, 32'd0);
        txn(1'b0, 32'h20, 32'd0, 1'b0, 32'h1);
    endtask

    task automatic test_latency0_random();
        int          r;
        int          idx;
        logic [31:0] a;
        logic [31:0] d;
        sel = 1'b1;
        #1;
        for (int i = 0; i < 256; i++) model_wr[i] = 1'b0;
        txn(1'b1, 32'h10, 32'hCAFEF00D, 1'b0, 32'd0);
        model_mem[4] = 32'hCAFEF00D;
        model_wr[4]  = 1'b1;
        txn(1'b0, 32'h10, 32'd0, 1'b0, 32'hCAFEF00D);
        for (int i = 0; i < 100; i++) begin
            r   = $urandom_range(0, 9);
            idx = $urandom_range(0, 255);
            d   = $urandom;
            if (r == 0) begin
                a = {22'd0, idx[7:0], 2'b00} | 32'($urandom_range(1, 3));
                txn(r[0], a, d, 1'b1, 32'd0);
            end else if (r == 1) begin
                a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
                txn(1'b0, a, d, 1'b1, 32'd0);
            end else if (r < 5 || !model_wr[idx]) begin
                a = {22'd0, idx[7:0], 2'b00};
                txn(1'b1, a, d, 1'b0, 32'd0);
                model_mem[idx] = d;
                model_wr[idx]  = 1'b1;
            end else begin
                a = {22'd0, idx[7:0], 2'b00};
                txn(1'b0, a, 32'd0, 1'b0, model_mem[idx]);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        sel        = 1'b0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_latency0_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder that serves load/store requests from the mini-MIPS datapath over a valid/ready request/response handshake. It replaces the zero-latency combinational data memory with a sequential slave that has a configurable wait-state latency, one outstanding transaction, and error reporting. It sits between the core's load/store path and on-chip SRAM and is the target side of the core's `mem_read`/`mem_write` traffic.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, at least 4.
- `LATENCY`, 2: wait-state cycles between request acceptance and response; 0..15.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; returns the FSM to IDLE.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: requester accepts the response.
- `resp_rdata` output 32: load data. Always 0 for stores and for errors.
- `resp_err` output 1: the request was misaligned or out of range.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `req_write`, `req_addr` and `req_wdata`.
  - If `LATENCY`=0, go to RESP; otherwise go to WAIT with the counter set to `LATENCY`-1.
- **WAIT**
  - `req_ready`=0 and `resp_valid`=0.
  - The counter decrements each cycle.
  - When the counter is 0, go to RESP at the next edge.
- **Array access and error check**
  - The access happens on the edge that enters RESP. Store: write the array. Load: capture array data into the `resp_rdata` register.
  - Word index = `addr[$clog2(DEPTH)+1:2]`.
  - Error if `addr[1:0]`≠0 or `addr[31:$clog2(DEPTH)+2]`≠0.
  - On error: the store is suppressed, `resp_rdata`=0 and `resp_err`=1.
- **RESP**
  - `resp_valid`=1; `resp_rdata` and `resp_err` are held stable.
  - On `resp_valid`&&`resp_ready`, go to IDLE.
- Only one transaction is outstanding at a time, so read-after-write ordering is inherent.
- Request inputs are ignored outside IDLE.
- A store still produces a response; it acts as the write acknowledge.
- Array contents are not cleared by reset. Contents are undefined until written.

## Timing
- **Reset values:** `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, state IDLE, counter 0.
- **Reset mid-transaction:** the transaction is dropped. A store not yet committed does not reach the array. A store already committed remains.
- **Response latency:** with acceptance at edge E0, `resp_valid` is high from edge E0+`LATENCY`.
- **Back-to-back throughput:** with `resp_ready` tied high, a transaction completes every `LATENCY`+2 cycles. The response handshake completes at edge E0+`LATENCY`+1 and the next acceptance happens at edge E0+`LATENCY`+2.
- **Backpressure:** if `resp_ready` is held low, RESP persists indefinitely and outputs do not change.
- **Output timing:** all outputs are registered or decoded from state only, with no combinational path from inputs.
  - `req_ready` = (state==IDLE).
  - `resp_valid` = (state==RESP).

## Structure
- **Shared package `mips_mem_pkg`:**
  - state encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2;
  - the counter width constant `LAT_W`=4;
  - a function computing the address-error flag from `addr` and `DEPTH`.
- **Sub-module `dmem_array`:** single-port synchronous RAM (`clk`, `we`, `addr`, `wdata`, `rdata`) with no reset. It must be inferable as block RAM.
- **Responder top:** holds the FSM, counter and request latch.

## Test plan
All scenarios use `DEPTH`=256 and `LATENCY`=2 unless stated otherwise.
1. Store 0xDEADBEEF to 0x10, then load 0x10.
   - Both get `resp_err`=0.
   - The load returns 0xDEADBEEF with `resp_valid` at E0+2.
   - `req_ready` is low for exactly 3 cycles per transaction with `resp_ready` tied high.
2. Store to 0x13 (misaligned), then load 0x10.
   - The store gets `resp_err`=1.
   - The load still returns 0xDEADBEEF, so the misaligned store was suppressed.
3. Load 0x400 (out of range) → `resp_err`=1, `resp_rdata`=0.
4. Hold `resp_ready`=0 for 5 cycles after a load of 0x10.
   - `resp_valid` stays 1 and `resp_rdata` stays 0xDEADBEEF.
   - `req_valid` with new requests is ignored.
   - After `resp_ready`=1, the handshake completes and `req_ready` returns next cycle.
5. Store 0x12345678 to 0x20 and assert `reset` one cycle after acceptance (in WAIT).
   - Outputs return to reset values immediately.
   - A store of 0x1 to 0x20 followed by a load of 0x20 returns 0x00000001, with no stale response.
6. `LATENCY`=0: load 0x10 after storing 0xCAFEF00D → `resp_valid` at E0 and data 0xCAFEF00D. A 100-transaction random store/load run against a reference model shows zero mismatches.
